// File: rtl/accel_spi_responder.sv
// Purpose: SPI mode-3 register responder for an accelerometer-style register map.
// Latency: SPI inputs cross SYNC_STAGES flops plus one edge-detect flop; writes commit on the detected 8th rising edge.
// Backpressure: none; the SPI initiator paces all transfers and sample_valid is always accepted.
//
// Ports:
//   slowclk, reset_n         block clock (>= 8x sclk_in), synchronous active-low reset
//   sclk_in, csn_in, mosi_in asynchronous SPI inputs from the initiator
//   miso_out, miso_oe        SPI read data and its drive enable
//   sample_x/y/z, sample_valid  new axis sample strobe
//   power_ctl, data_format   register 0x2D / 0x31 contents
//   int1                     DATA_READY gated by INT_ENABLE[7]
module accel_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2       // must be >= 2
) (
    input  logic        slowclk,
    input  logic        reset_n,
    input  logic        sclk_in,
    input  logic        csn_in,
    input  logic        mosi_in,
    output logic        miso_out,
    output logic        miso_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic [7:0]  power_ctl,
    output logic [7:0]  data_format,
    output logic        int1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Synchronizers and edge-detect delay flops, reset to bus idle levels.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   csn_d;

    logic sclk_s;
    logic csn_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic csn_fall;

    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_shift;
    logic        rw;
    logic        mb;
    logic [5:0]  addr;
    logic        byte_done;

    logic [7:0]  int_enable;
    logic        data_ready;
    logic [15:0] live_x, live_y, live_z;
    logic [15:0] snap_x, snap_y, snap_z;
    logic [7:0]  rd_data;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign csn_fall  = ~csn_s & csn_d;

    // Completed byte includes the bit being sampled on this rising edge.
    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !csn_s && (state != IDLE);

    always_ff @(posedge slowclk) begin
        if (!reset_n) begin
            sclk_sync <= '1;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b1;
            csn_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            sclk_d    <= sclk_s;
            csn_d     <= csn_s;
        end
    end

    always_ff @(posedge slowclk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (csn_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (csn_fall) state_nxt = ADDR;
                ADDR:    if (byte_done) state_nxt = DATA;
                DATA:    state_nxt = DATA;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Register read mux; sample bytes come from the per-transaction snapshot.
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            6'h00:   rd_data = DEVID;
            6'h2D:   rd_data = power_ctl;
            6'h2E:   rd_data = int_enable;
            6'h30:   rd_data = {data_ready, 7'b0};
            6'h31:   rd_data = data_format;
            6'h32:   rd_data = snap_x[7:0];
            6'h33:   rd_data = snap_x[15:8];
            6'h34:   rd_data = snap_y[7:0];
            6'h35:   rd_data = snap_y[15:8];
            6'h36:   rd_data = snap_z[7:0];
            6'h37:   rd_data = snap_z[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge slowclk) begin
        if (!reset_n) begin
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            miso_oe     <= 1'b0;
            rw          <= 1'b0;
            mb          <= 1'b0;
            addr        <= 6'h00;
            power_ctl   <= 8'h00;
            data_format <= 8'h00;
            int_enable  <= 8'h00;
            data_ready  <= 1'b0;
            live_x      <= 16'h0;
            live_y      <= 16'h0;
            live_z      <= 16'h0;
            snap_x      <= 16'h0;
            snap_y      <= 16'h0;
            snap_z      <= 16'h0;
        end else begin
            if (csn_s || csn_fall) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise && state != IDLE) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte;
            end

            if (state == ADDR && byte_done) begin
                rw   <= rx_byte[7];
                mb   <= rx_byte[6];
                addr <= rx_byte[5:0];
            end

            if (state == DATA && byte_done) begin
                if (!rw) begin
                    case (addr)
                        6'h2D:   power_ctl   <= rx_byte;
                        6'h2E:   int_enable  <= rx_byte;
                        6'h31:   data_format <= rx_byte;
                        default: ;
                    endcase
                end
                if (mb) begin
                    addr <= addr + 6'd1;
                end
            end

            // Read data: load on the first falling edge of each byte, shift after.
            if (csn_s || state == IDLE) begin
                miso_oe <= 1'b0;
            end else if (state == DATA && rw && sclk_fall) begin
                if (bit_cnt == 3'd0) begin
                    tx_shift <= rd_data;
                    miso_oe  <= 1'b1;
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end

            if (sample_valid) begin
                live_x <= sample_x;
                live_y <= sample_y;
                live_z <= sample_z;
            end

            // Snapshot at transaction start so multi-byte reads are coherent.
            if (csn_fall) begin
                snap_x <= sample_valid ? sample_x : live_x;
                snap_y <= sample_valid ? sample_y : live_y;
                snap_z <= sample_valid ? sample_z : live_z;
            end

            // Set has priority over the read-of-0x37 clear.
            if (sample_valid) begin
                data_ready <= 1'b1;
            end else if (state == DATA && rw && byte_done && addr == 6'h37) begin
                data_ready <= 1'b0;
            end
        end
    end

    assign miso_out = miso_oe & tx_shift[7];
    assign int1     = data_ready & int_enable[7];

endmodule
